oled_power_sequencer: RTL and testbench

- Controls the ZedBoard OLED (SSD1306) power-up sequence.
- Drives the VDD, VBAT and RES rails and issues the init command bytes to the SPI byte transmitter.
- Times every wait with the existing millisecond delay generator: drives its enable, consumes its one-cycle done pulse.
- Sits between top-level control and the SPI/delay stages; init_done gates the downstream pixel-write logic.

---
 rtl/oled_pkg.sv | 40 ++++
 rtl/oled_init_rom.sv | 28 ++
 rtl/oled_power_sequencer.sv | 132 +++++++++++++
 tb/tb_oled_power_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared state encoding, init command bytes and command-block boundaries for the OLED sequencer.
package oled_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_VDD_ON,
    ST_WAIT_VDD,
    ST_RES_LOW,
    ST_WAIT_RES,
    ST_RES_HIGH,
    ST_WAIT_RES2,
    ST_VBAT_ON,
    ST_WAIT_VBAT,
    ST_DGAP,
    ST_SEND,
    ST_SGAP,
    ST_DONE
  } state_t;

  localparam int NUM_CMDS = 12;

  localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
  localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
  localparam logic [7:0] CMD_CP_ENABLE     = 8'h14;
  localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
  localparam logic [7:0] CMD_PRECHARGE_VAL = 8'hF1;
  localparam logic [7:0] CMD_CONTRAST      = 8'h81;
  localparam logic [7:0] CMD_CONTRAST_VAL  = 8'h0F;
  localparam logic [7:0] CMD_SEG_REMAP     = 8'hA0;
  localparam logic [7:0] CMD_COM_SCAN_DIR  = 8'hC0;
  localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
  localparam logic [7:0] CMD_COM_PINS_VAL  = 8'h00;
  localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;

  // Last index of each command block; the sequencer changes phase after these.
  localparam logic [3:0] IDX_BLK0_END = 4'd0;
  localparam logic [3:0] IDX_BLK1_END = 4'd4;
  localparam logic [3:0] IDX_BLK2_END = 4'(NUM_CMDS - 1);

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 init command ROM: combinational index-to-byte lookup, zero latency, no flow control.
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [3:0] index,
  output logic [7:0] command
);

  always_comb begin
    command = 8'h00;
    case (index)
      4'd0:    command = CMD_DISPLAY_OFF;
      4'd1:    command = CMD_CHARGE_PUMP;
      4'd2:    command = CMD_CP_ENABLE;
      4'd3:    command = CMD_PRECHARGE;
      4'd4:    command = CMD_PRECHARGE_VAL;
      4'd5:    command = CMD_CONTRAST;
      4'd6:    command = CMD_CONTRAST_VAL;
      4'd7:    command = CMD_SEG_REMAP;
      4'd8:    command = CMD_COM_SCAN_DIR;
      4'd9:    command = CMD_COM_PINS;
      4'd10:   command = CMD_COM_PINS_VAL;
      4'd11:   command = CMD_DISPLAY_ON;
      default: command = 8'h00;
    endcase
  end

endmodule

// File: rtl/oled_power_sequencer.sv
// SSD1306 power-up: rails and init bytes in order, each delay/SPI request held until its done pulse,
// then one idle gap cycle; all outputs registered, stray done pulses are ignored.
module oled_power_sequencer
  import oled_pkg::*;
#(
  parameter int VBAT_WAIT_UNITS = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       delay_enable,
  input  logic       delay_done,
  output logic [7:0] spi_data,
  output logic       spi_send,
  input  logic       spi_done,
  output logic       oled_dc,
  output logic       oled_res,
  output logic       oled_vdd,
  output logic       oled_vbat,
  output logic       busy,
  output logic       init_done
);

  localparam int UW = $clog2(VBAT_WAIT_UNITS + 1);

  state_t        state;
  state_t        wait_src;
  logic [3:0]    idx;
  logic [UW-1:0] unit_cnt;
  logic [7:0]    rom_byte;

  oled_init_rom u_rom (
    .index   (idx),
    .command (rom_byte)
  );

  assign oled_dc = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_src     <= ST_IDLE;
      idx          <= '0;
      unit_cnt     <= '0;
      delay_enable <= 1'b0;
      spi_send     <= 1'b0;
      spi_data     <= 8'h00;
      oled_res     <= 1'b1;
      oled_vdd     <= 1'b1;
      oled_vbat    <= 1'b1;
      busy         <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ST_VDD_ON;
          end
        end
        ST_VDD_ON: begin
          oled_vdd     <= 1'b0;
          delay_enable <= 1'b1;
          state        <= ST_WAIT_VDD;
        end
        ST_WAIT_VDD, ST_WAIT_RES, ST_WAIT_RES2, ST_WAIT_VBAT: begin
          if (delay_done) begin
            delay_enable <= 1'b0;
            wait_src     <= state;
            state        <= ST_DGAP;
            if (state == ST_WAIT_VBAT) unit_cnt <= unit_cnt + UW'(1);
          end
        end
        // wait_src remembers which wait just finished so one gap state serves all of them.
        ST_DGAP: begin
          if (wait_src == ST_WAIT_RES) begin
            state <= ST_RES_HIGH;
          end else if (wait_src == ST_WAIT_VBAT && unit_cnt != UW'(VBAT_WAIT_UNITS)) begin
            delay_enable <= 1'b1;
            state        <= ST_WAIT_VBAT;
          end else begin
            spi_send <= 1'b1;
            spi_data <= rom_byte;
            state    <= ST_SEND;
          end
        end
        ST_RES_LOW: begin
          oled_res     <= 1'b0;
          delay_enable <= 1'b1;
          state        <= ST_WAIT_RES;
        end
        ST_RES_HIGH: begin
          oled_res     <= 1'b1;
          delay_enable <= 1'b1;
          state        <= ST_WAIT_RES2;
        end
        ST_VBAT_ON: begin
          oled_vbat    <= 1'b0;
          delay_enable <= 1'b1;
          unit_cnt     <= '0;
          state        <= ST_WAIT_VBAT;
        end
        ST_SEND: begin
          if (spi_done) begin
            spi_send <= 1'b0;
            idx      <= idx + 4'd1;
            state    <= ST_SGAP;
          end
        end
        // idx already points past the byte just sent.
        ST_SGAP: begin
          if (idx == IDX_BLK0_END + 4'd1) begin
            state <= ST_RES_LOW;
          end else if (idx == IDX_BLK1_END + 4'd1) begin
            state <= ST_VBAT_ON;
          end else if (idx == IDX_BLK2_END + 4'd1) begin
            init_done <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_DONE;
          end else begin
            spi_send <= 1'b1;
            spi_data <= rom_byte;
            state    <= ST_SEND;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Randomized bench: delay/SPI responders with stray pulses, a table-driven sequence model, per-cycle compare.
module tb_oled_power_sequencer;

  localparam int VBAT  = 3;
  localparam int BOUND = 3000;

  logic       clock = 1'b0;
  logic       reset, start, delay_done, spi_done;
  logic       delay_enable, spi_send, oled_dc, oled_res, oled_vdd, oled_vbat, busy, init_done;
  logic [7:0] spi_data;

  int checks = 0;
  int errors = 0;

  oled_power_sequencer #(.VBAT_WAIT_UNITS(VBAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .delay_enable (delay_enable),
    .delay_done   (delay_done),
    .spi_data     (spi_data),
    .spi_send     (spi_send),
    .spi_done     (spi_done),
    .oled_dc      (oled_dc),
    .oled_res     (oled_res),
    .oled_vdd     (oled_vdd),
    .oled_vbat    (oled_vbat),
    .busy         (busy),
    .init_done    (init_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pins();
    return {oled_vdd, oled_vbat, oled_res, oled_dc, delay_enable, spi_send, busy, init_done};
  endfunction

  // ---------------- stimulus / responders (act 1 time unit after negedge) ----------------
  bit start_req, stray_en, chaos_en, cmp_en;
  int late_sd_cnt, dcnt, dlen, scnt, slen, dd_real;

  always @(negedge clock) begin
    #1;
    if (!delay_enable) begin
      dcnt       = 0;
      delay_done = 1'b0;
    end else begin
      dcnt++;
      delay_done = (dcnt >= dlen);
      if (delay_done) begin
        dcnt = 0;
        dlen = $urandom_range(12, 3);
        dd_real++;
      end
    end
    if (!spi_send) begin
      scnt     = 0;
      spi_done = 1'b0;
    end else if (spi_done) begin
      scnt     = 0;
      spi_done = 1'b0;
    end else begin
      scnt++;
      spi_done = (scnt >= slen);
      if (spi_done) slen = $urandom_range(6, 1);
    end
    if (stray_en && !delay_enable && $urandom_range(15, 0) == 0) delay_done = 1'b1;
    if (stray_en && !spi_send && $urandom_range(15, 0) == 0) spi_done = 1'b1;
    if (late_sd_cnt > 0) begin
      spi_done = 1'b1;
      late_sd_cnt--;
    end
    start = start_req | (chaos_en && (busy || init_done) && $urandom_range(7, 0) == 0);
  end

  // ---------------- behavioural model: the power-up script as a table of steps ----------------
  localparam int OP_IDLE = 0, OP_RAIL = 1, OP_WAIT = 2, OP_SEND = 3, OP_DONE = 4;
  localparam int R_VDD = 0, R_RES = 1, R_VBAT = 2;

  int         op_kind [13];
  int         op_a    [13];
  int         op_b    [13];
  logic [7:0] exp_bytes [12];

  logic       m_vdd, m_vbat, m_res, m_en, m_send, m_busy, m_init;
  logic [7:0] m_data;
  int         pc, units_left, sidx;
  bit         gap;

  task automatic set_op(input int i, input int k, input int a, input int b);
    op_kind[i] = k;
    op_a[i]    = a;
    op_b[i]    = b;
  endtask

  task automatic enter(input int p);
    pc  = p;
    gap = 0;
    case (op_kind[p])
      OP_WAIT: begin m_en = 1'b1; units_left = op_a[p]; end
      OP_SEND: begin sidx = op_a[p]; m_send = 1'b1; m_data = exp_bytes[sidx]; end
      OP_DONE: begin m_init = 1'b1; m_busy = 1'b0; end
      default: ;
    endcase
  endtask

  always @(posedge clock) begin
    if (reset) begin
      {m_vdd, m_vbat, m_res} = 3'b111;
      {m_en, m_send, m_busy, m_init} = 4'b0000;
      m_data = 8'h00;
      pc  = 0;
      gap = 0;
    end else begin
      case (op_kind[pc])
        OP_IDLE: if (start) begin m_busy = 1'b1; enter(pc + 1); end
        OP_RAIL: begin
          case (op_a[pc])
            R_VDD:   m_vdd  = op_b[pc][0];
            R_RES:   m_res  = op_b[pc][0];
            default: m_vbat = op_b[pc][0];
          endcase
          enter(pc + 1);
        end
        OP_WAIT: begin
          if (!gap) begin
            if (delay_done) begin m_en = 1'b0; units_left--; gap = 1; end
          end else if (units_left > 0) begin
            m_en = 1'b1;
            gap  = 0;
          end else enter(pc + 1);
        end
        OP_SEND: begin
          if (!gap) begin
            if (spi_done) begin m_send = 1'b0; sidx++; gap = 1; end
          end else if (sidx <= op_b[pc]) begin
            m_send = 1'b1;
            m_data = exp_bytes[sidx];
            gap    = 0;
          end else enter(pc + 1);
        end
        default: ;
      endcase
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("pins", 32'(pins()), 32'({m_vdd, m_vbat, m_res, 1'b0, m_en, m_send, m_busy, m_init}));
      if (m_send) check("spi_data", 32'(spi_data), 32'(m_data));
    end
  end

  // ---------------- monitor: byte capture and VBAT-window properties ----------------
  logic [7:0] got[$];
  bit         prev_send, prev_vbat, prev_en, in_win;
  int         low_run, vbat_dd0;

  always @(negedge clock) begin
    if (cmp_en) begin
      if (in_win && delay_enable && !prev_en) check("vbat_gap_cycles", 32'(low_run), 1);
      if (prev_vbat && !oled_vbat) begin
        in_win   = 1;
        vbat_dd0 = dd_real;
        check("vbat_order", {oled_vdd, (got.size() >= 3)}, 'b01);
      end
      if (spi_send && !prev_send) begin
        got.push_back(spi_data);
        if (in_win) begin
          in_win = 0;
          check("vbat_units", 32'(dd_real - vbat_dd0), VBAT);
          check("byte_after_vbat", 32'(spi_data), 'h81);
        end
      end
    end
    low_run   = delay_enable ? 0 : low_run + 1;
    prev_send = spi_send;
    prev_vbat = oled_vbat;
    prev_en   = delay_enable;
  end

  // ---------------- directed flow ----------------
  task automatic new_run();
    got.delete();
    dd_real = 0;
    in_win  = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start_req = 1;
    @(negedge clock);
    start_req = 0;
  endtask

  task automatic wait_done_and_check(input string tag);
    for (int i = 0; i < BOUND && !init_done; i++) @(negedge clock);
    check({tag, "_done_reached"}, 32'(init_done), 1);
    check({tag, "_count"}, 32'(got.size()), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF,
            32'(exp_bytes[i]));
    check({tag, "_flags"}, {init_done, busy}, 'b10);
  endtask

  initial begin
    logic [7:0] tbl [12];
    tbl = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
    for (int i = 0; i < 12; i++) exp_bytes[i] = tbl[i];
    set_op(0,  OP_IDLE, 0,      0);
    set_op(1,  OP_RAIL, R_VDD,  0);
    set_op(2,  OP_WAIT, 1,      0);
    set_op(3,  OP_SEND, 0,      0);
    set_op(4,  OP_RAIL, R_RES,  0);
    set_op(5,  OP_WAIT, 1,      0);
    set_op(6,  OP_RAIL, R_RES,  1);
    set_op(7,  OP_WAIT, 1,      0);
    set_op(8,  OP_SEND, 1,      4);
    set_op(9,  OP_RAIL, R_VBAT, 0);
    set_op(10, OP_WAIT, VBAT,   0);
    set_op(11, OP_SEND, 5,      11);
    set_op(12, OP_DONE, 0,      0);

    reset = 1; start = 0; delay_done = 0; spi_done = 0;
    start_req = 0; stray_en = 0; chaos_en = 0; cmp_en = 0; late_sd_cnt = 0;
    dlen = 10; slen = 4; dcnt = 0; scnt = 0; dd_real = 0; low_run = 0;
    repeat (2) @(negedge clock);
    cmp_en = 1;
    check("reset_pins", 32'(pins()), 'hE0);
    check("reset_data", 32'(spi_data), 0);
    reset = 0;
    repeat (3) @(negedge clock);
    check("idle_hold", 32'(pins()), 'hE0);

    // Run 1: strays and repeated start pulses throughout.
    new_run();
    stray_en = 1;
    chaos_en = 1;
    pulse_start();
    check("start_busy_vdd", {busy, oled_vdd}, 'b11);
    @(negedge clock);
    check("vdd_on", {oled_vdd, delay_enable}, 'b01);
    for (int i = 0; i < BOUND && !spi_send; i++) @(negedge clock);
    check("first_byte", 32'(spi_data), 'hAE);
    check("dd_before_first_byte", 32'(dd_real), 1);
    check("busy_in_run", 32'(busy), 1);
    wait_done_and_check("run1");

    repeat (4) begin
      pulse_start();
      repeat (3) @(negedge clock);
    end
    check("done_no_restart", {32'(got.size()), init_done, busy}, {32'd12, 2'b10});

    // Run 2: reset while D9 is in flight, late spi_done, then a clean replay.
    reset = 1;
    @(negedge clock);
    reset = 0;
    new_run();
    pulse_start();
    for (int i = 0; i < BOUND && !(spi_send && spi_data == 8'hD9); i++) @(negedge clock);
    check("d9_in_flight", {spi_send, spi_data}, 'h1D9);
    reset = 1;
    @(negedge clock);
    check("midrun_reset_pins", 32'(pins()), 'hE0);
    check("midrun_reset_data", 32'(spi_data), 0);
    reset = 0;
    late_sd_cnt = 2;
    repeat (5) @(negedge clock);
    check("late_done_ignored", 32'(pins()), 'hE0);

    new_run();
    pulse_start();
    wait_done_and_check("replay");

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
